// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding and seven-segment constants for the scan controller
package seg_pkg;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low cathode patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - frame input and display output bundle of the scan controller
interface seg_scan_ctrl_if;

    logic [15:0] digits;
    logic [3:0]  digit_mask;
    logic [3:0]  dp_in;
    logic [1:0]  sel;
    logic        en;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output digits, digit_mask, dp_in,
        input  sel, en, seg, dp, frame_start
    );

    modport slave (
        input  digits, digit_mask, dp_in,
        output sel, en, seg, dp, frame_start
    );

endinterface

// File: rtl/seg7_hex.sv
// rtl/seg7_hex.sv - combinational hex nibble to active-low seven-segment pattern
module seg7_hex
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (nibble)
            4'h0: pattern = HEX_0;
            4'h1: pattern = HEX_1;
            4'h2: pattern = HEX_2;
            4'h3: pattern = HEX_3;
            4'h4: pattern = HEX_4;
            4'h5: pattern = HEX_5;
            4'h6: pattern = HEX_6;
            4'h7: pattern = HEX_7;
            4'h8: pattern = HEX_8;
            4'h9: pattern = HEX_9;
            4'hA: pattern = HEX_A;
            4'hB: pattern = HEX_B;
            4'hC: pattern = HEX_C;
            4'hD: pattern = HEX_D;
            4'hE: pattern = HEX_E;
            4'hF: pattern = HEX_F;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit seven-segment scan controller with frame latch and inter-digit blanking
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int BLANK_CYCLES = 1000,
    parameter int SHOW_CYCLES  = 99000
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYCLES - 1);
    localparam logic [19:0] SHOW_LAST  = 20'(SHOW_CYCLES - 1);

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [19:0] cnt;
    logic [19:0] cnt_next;
    logic [1:0]  sel_q;
    logic [1:0]  sel_next;

    logic [15:0] frame_digits;
    logic [3:0]  frame_mask;
    logic [3:0]  frame_dp;
    logic [15:0] digits_eff;
    logic [3:0]  mask_eff;
    logic [3:0]  dp_eff;

    logic        latch_now;
    logic        lit_next;
    logic [3:0]  nibble_next;
    logic [6:0]  hex_pat;

    logic        en_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic        frame_start_q;

    assign latch_now = (state == ST_BLANK) && (sel_q == 2'd0) && (cnt == 20'd0);

    // With a one-cycle blank the latch edge is also the SHOW entry edge, so bypass the frame registers
    assign digits_eff = latch_now ? bus.digits     : frame_digits;
    assign mask_eff   = latch_now ? bus.digit_mask : frame_mask;
    assign dp_eff     = latch_now ? bus.dp_in      : frame_dp;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 20'd1;
        sel_next   = sel_q;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = ST_SHOW;
                    cnt_next   = 20'd0;
                end
            end
            default: begin
                if (cnt == SHOW_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = 20'd0;
                    sel_next   = sel_q + 2'd1;
                end
            end
        endcase
    end

    assign nibble_next = digits_eff[{sel_next, 2'b00} +: 4];
    assign lit_next    = (state_next == ST_SHOW) && !mask_eff[sel_next];

    seg7_hex u_hex (
        .nibble  (nibble_next),
        .pattern (hex_pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_BLANK;
            cnt           <= 20'd0;
            sel_q         <= 2'd0;
            en_q          <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
            frame_digits  <= 16'd0;
            frame_mask    <= 4'd0;
            frame_dp      <= 4'd0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            sel_q         <= sel_next;
            frame_start_q <= latch_now;
            if (latch_now) begin
                frame_digits <= bus.digits;
                frame_mask   <= bus.digit_mask;
                frame_dp     <= bus.dp_in;
            end
            en_q  <= lit_next;
            seg_q <= lit_next ? hex_pat : SEG_OFF;
            dp_q  <= lit_next ? ~dp_eff[sel_next] : 1'b1;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.en          = en_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench: cycle-count model plus directed literal checks
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clk = ~clk;

    seg_scan_ctrl_if if_a ();
    seg_scan_ctrl_if if_b ();

    seg_scan_ctrl #(.BLANK_CYCLES(2), .SHOW_CYCLES(3)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a)
    );

    seg_scan_ctrl #(.BLANK_CYCLES(1), .SHOW_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_hex(input logic [3:0] v);
        case (v)
            4'h0: exp_hex = 7'h40;  4'h1: exp_hex = 7'h79;
            4'h2: exp_hex = 7'h24;  4'h3: exp_hex = 7'h30;
            4'h4: exp_hex = 7'h19;  4'h5: exp_hex = 7'h12;
            4'h6: exp_hex = 7'h02;  4'h7: exp_hex = 7'h78;
            4'h8: exp_hex = 7'h00;  4'h9: exp_hex = 7'h10;
            4'hA: exp_hex = 7'h08;  4'hB: exp_hex = 7'h03;
            4'hC: exp_hex = 7'h46;  4'hD: exp_hex = 7'h21;
            4'hE: exp_hex = 7'h06;  default: exp_hex = 7'h0E;
        endcase
    endfunction

    // n counts clock edges since the last reset edge; outputs follow from position in the frame
    task automatic model_out(input int n, input int b, input int s,
                             input logic [15:0] fd, input logic [3:0] fm, input logic [3:0] fp,
                             output logic [1:0] e_sel, output logic e_en, output logic [6:0] e_seg,
                             output logic e_dp, output logic e_fs);
        int slot_len;
        int pos;
        int slot;
        int off;
        logic lit;
        slot_len = b + s;
        pos      = n % (4 * slot_len);
        slot     = pos / slot_len;
        off      = pos % slot_len;
        lit      = (off >= b) && !fm[slot];
        e_sel    = slot[1:0];
        e_en     = lit;
        e_seg    = lit ? exp_hex(fd[slot*4 +: 4]) : 7'h7F;
        e_dp     = lit ? ~fp[slot] : 1'b1;
        e_fs     = (pos == 1);
    endtask

    int          na = 0;
    int          nb = 0;
    logic        started_a = 1'b0;
    logic        started_b = 1'b0;
    logic [15:0] fda = '0, fdb = '0;
    logic [3:0]  fma = '0, fmb = '0, fpa = '0, fpb = '0;

    always @(posedge clk) begin
        if (reset_a) begin
            na <= 0; fda <= '0; fma <= '0; fpa <= '0; started_a <= 1'b1;
        end else begin
            na <= na + 1;
            if ((na + 1) % 20 == 1) begin
                fda <= if_a.digits; fma <= if_a.digit_mask; fpa <= if_a.dp_in;
            end
        end
        if (reset_b) begin
            nb <= 0; fdb <= '0; fmb <= '0; fpb <= '0; started_b <= 1'b1;
        end else begin
            nb <= nb + 1;
            if ((nb + 1) % 8 == 1) begin
                fdb <= if_b.digits; fmb <= if_b.digit_mask; fpb <= if_b.dp_in;
            end
        end
    end

    logic       prev_en_a = 1'b0, prev_en_b = 1'b0;
    logic [1:0] prev_sel_a = '0, prev_sel_b = '0;

    always @(negedge clk) begin : compare
        logic [1:0] es;
        logic       ee;
        logic [6:0] eg;
        logic       ed;
        logic       ef;
        if (started_a) begin
            model_out(na, 2, 3, fda, fma, fpa, es, ee, eg, ed, ef);
            check("a.sel", 16'(if_a.sel), 16'(es));
            check("a.en", 16'(if_a.en), 16'(ee));
            check("a.seg", 16'(if_a.seg), 16'(eg));
            check("a.dp", 16'(if_a.dp), 16'(ed));
            check("a.frame_start", 16'(if_a.frame_start), 16'(ef));
            if (prev_en_a && if_a.en) check("a.sel_hold", 16'(if_a.sel), 16'(prev_sel_a));
        end
        if (started_b) begin
            model_out(nb, 1, 1, fdb, fmb, fpb, es, ee, eg, ed, ef);
            check("b.sel", 16'(if_b.sel), 16'(es));
            check("b.en", 16'(if_b.en), 16'(ee));
            check("b.seg", 16'(if_b.seg), 16'(eg));
            check("b.dp", 16'(if_b.dp), 16'(ed));
            check("b.frame_start", 16'(if_b.frame_start), 16'(ef));
            if (prev_en_b && if_b.en) check("b.sel_hold", 16'(if_b.sel), 16'(prev_sel_b));
        end
        prev_en_a  <= if_a.en;
        prev_sel_a <= if_a.sel;
        prev_en_b  <= if_b.en;
        prev_sel_b <= if_b.sel;
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic goto_a(input int k);
        int guard;
        guard = 0;
        while (na != k && guard < 500) begin
            step(1);
            guard++;
        end
        if (na != k) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_a: reached %0d expected %0d", na, k);
        end
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        if_a.digits = 16'h1234; if_a.digit_mask = 4'h0; if_a.dp_in = 4'h0;
        if_b.digits = 16'hF0F0; if_b.digit_mask = 4'h0; if_b.dp_in = 4'h0;
        step(2);
        reset_a = 1'b0;
        reset_b = 1'b0;
        check("lit.a.rst_en", 16'(if_a.en), 16'h0);
        check("lit.a.rst_seg", 16'(if_a.seg), 16'h7F);
        check("lit.a.rst_dp", 16'(if_a.dp), 16'h1);
        check("lit.a.rst_fs", 16'(if_a.frame_start), 16'h0);
        step(1);
        check("lit.a.fs_first", 16'(if_a.frame_start), 16'h1);
        check("lit.a.en_blank", 16'(if_a.en), 16'h0);
        check("lit.b.en1", 16'(if_b.en), 16'h1);
        check("lit.b.seg1", 16'(if_b.seg), 16'h40);
        step(1);
        check("lit.a.en_show", 16'(if_a.en), 16'h1);
        check("lit.a.seg_d0", 16'(if_a.seg), 16'h19);
        check("lit.a.sel0", 16'(if_a.sel), 16'h0);
        check("lit.b.en2", 16'(if_b.en), 16'h0);
        check("lit.b.seg2", 16'(if_b.seg), 16'h7F);
        check("lit.b.sel2", 16'(if_b.sel), 16'h1);
        step(1);
        check("lit.b.seg3", 16'(if_b.seg), 16'h0E);
        check("lit.b.sel3", 16'(if_b.sel), 16'h1);
        goto_a(7);
        check("lit.a.seg_d1", 16'(if_a.seg), 16'h30);
        check("lit.a.sel1", 16'(if_a.sel), 16'h1);
        goto_a(12);
        check("lit.a.seg_d2", 16'(if_a.seg), 16'h24);
        if_a.digits = 16'hABCD;
        goto_a(17);
        check("lit.a.seg_d3_old", 16'(if_a.seg), 16'h79);
        goto_a(21);
        check("lit.a.fs_period", 16'(if_a.frame_start), 16'h1);
        goto_a(22);
        check("lit.a.seg_new_d0", 16'(if_a.seg), 16'h21);
        goto_a(37);
        check("lit.a.seg_new_d3", 16'(if_a.seg), 16'h08);
        goto_a(38);
        if_a.digit_mask = 4'b0101;
        if_a.dp_in      = 4'b1000;
        goto_a(42);
        check("lit.a.mask_en", 16'(if_a.en), 16'h0);
        check("lit.a.mask_seg", 16'(if_a.seg), 16'h7F);
        goto_a(57);
        check("lit.a.dp_sel", 16'(if_a.sel), 16'h3);
        check("lit.a.dp_en", 16'(if_a.en), 16'h1);
        check("lit.a.dp_low", 16'(if_a.dp), 16'h0);
        goto_a(73);
        reset_a = 1'b1;
        step(1);
        reset_a = 1'b0;
        check("lit.a.midrst_en", 16'(if_a.en), 16'h0);
        check("lit.a.midrst_seg", 16'(if_a.seg), 16'h7F);
        check("lit.a.midrst_sel", 16'(if_a.sel), 16'h0);
        step(1);
        check("lit.a.midrst_fs", 16'(if_a.frame_start), 16'h1);
        goto_a(200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
